// File: rtl/pipelined_control_unit_pkg.sv
// Shared control typedefs, encodings and pipeline register layouts.
package pipelined_control_unit_pkg;
  localparam int PKG_XLEN = 32;
  localparam logic [PKG_XLEN-1:0] PC_STEP = 32'd4;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  localparam logic [2:0] RES_ALU = 3'd0, RES_MEM = 3'd1, RES_PC4 = 3'd2, RES_IMM = 3'd3;

  typedef enum logic [2:0] {
    IT_NONE = 3'd0, IT_R, IT_I, IT_S, IT_B, IT_U, IT_J
  } InstructionTypes;

  typedef enum logic [3:0] {
    IST_NONE = 4'd0, IST_ALU, IST_ALU_IMM, IST_LOAD, IST_STORE,
    IST_BRANCH, IST_JAL, IST_JALR, IST_LUI, IST_AUIPC
  } InstructionSubTypes;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PKG_XLEN-1:0] pc;
    logic                valid;
  } if_id_t;

  typedef struct packed {
    logic                valid;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] imm_ext;
    logic                reg_write;
    logic                mem_write;
    logic                alu_src;
    logic [3:0]          alu_control;
    logic [2:0]          result_src;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    InstructionTypes     itype;
    InstructionSubTypes  isub;
  } id_ex_ctrl_t;

  // funct3/funct7[5] to ALU op; the alternate bit only selects SUB on R-type.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational RV32I control decoder shared with the single-cycle core.
module control_decoder
  import pipelined_control_unit_pkg::*;
(
  input  logic [31:0]        iInstr,
  input  logic               iZero,
  output logic               oRegWrite,
  output logic               oMemWrite,
  output logic               oAluSrc,
  output logic               oPCSrc,
  output logic [3:0]         oAluControl,
  output logic [2:0]         oResultSrc,
  output logic [31:0]        oImmExt,
  output logic [4:0]         oRs1,
  output logic [4:0]         oRs2,
  output logic [4:0]         oRd,
  output InstructionTypes    oType,
  output InstructionSubTypes oSubType
);
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_alt;

  assign w_op  = iInstr[6:0];
  assign w_f3  = iInstr[14:12];
  assign w_alt = iInstr[30];
  assign oRs1  = iInstr[19:15];
  assign oRs2  = iInstr[24:20];
  assign oRd   = iInstr[11:7];

  // Opcode decode; unknown opcodes decode to an all-zero (no side effect) control word.
  always_comb begin
    oRegWrite   = 1'b0;
    oMemWrite   = 1'b0;
    oAluSrc     = 1'b0;
    oPCSrc      = 1'b0;
    oAluControl = ALU_ADD;
    oResultSrc  = RES_ALU;
    oImmExt     = '0;
    oType       = IT_NONE;
    oSubType    = IST_NONE;
    case (w_op)
      7'b0110011: begin
        oType = IT_R; oSubType = IST_ALU; oRegWrite = 1'b1;
        oAluControl = alu_decode(w_f3, w_alt, 1'b1);
      end
      7'b0010011: begin
        oType = IT_I; oSubType = IST_ALU_IMM; oRegWrite = 1'b1; oAluSrc = 1'b1;
        oImmExt = {{20{iInstr[31]}}, iInstr[31:20]};
        oAluControl = alu_decode(w_f3, w_alt, 1'b0);
      end
      7'b0000011: begin
        oType = IT_I; oSubType = IST_LOAD; oRegWrite = 1'b1; oAluSrc = 1'b1;
        oResultSrc = RES_MEM; oImmExt = {{20{iInstr[31]}}, iInstr[31:20]};
      end
      7'b0100011: begin
        oType = IT_S; oSubType = IST_STORE; oMemWrite = 1'b1; oAluSrc = 1'b1;
        oImmExt = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
      end
      7'b1100011: begin
        oType = IT_B; oSubType = IST_BRANCH; oAluControl = ALU_SUB;
        oPCSrc = iZero ^ w_f3[0];
        oImmExt = {{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25], iInstr[11:8], 1'b0};
      end
      7'b1101111: begin
        oType = IT_J; oSubType = IST_JAL; oRegWrite = 1'b1; oPCSrc = 1'b1;
        oResultSrc = RES_PC4;
        oImmExt = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20], iInstr[30:21], 1'b0};
      end
      7'b1100111: begin
        oType = IT_I; oSubType = IST_JALR; oRegWrite = 1'b1; oAluSrc = 1'b1; oPCSrc = 1'b1;
        oResultSrc = RES_PC4; oImmExt = {{20{iInstr[31]}}, iInstr[31:20]};
      end
      7'b0110111: begin
        oType = IT_U; oSubType = IST_LUI; oRegWrite = 1'b1; oResultSrc = RES_IMM;
        oImmExt = {iInstr[31:12], 12'b0};
      end
      7'b0010111: begin
        oType = IT_U; oSubType = IST_AUIPC; oRegWrite = 1'b1; oAluSrc = 1'b1;
        oImmExt = {iInstr[31:12], 12'b0};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/pipelined_control_unit_imem.sv
// Instruction memory: combinational read, synchronous program-load write.
module instr_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              iClk,
  input  logic              iWe,
  input  logic [ADDR_W-1:0] iWAddr,
  input  logic [31:0]       iWData,
  input  logic [ADDR_W-1:0] iAddr,
  output logic [31:0]       oRdata
);
  logic [31:0] r_mem [2**ADDR_W];

  // Program load path; not reset so contents survive a core reset.
  always_ff @(posedge iClk) begin
    if (iWe) r_mem[iWAddr] <= iWData;
  end

  assign oRdata = r_mem[iAddr];
endmodule

// File: rtl/pipelined_control_unit_pc_sequencer.sv
// Program counter with redirect > stall > sequential priority.
module pc_sequencer
  import pipelined_control_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iStall,
  input  logic            iBranchTaken,
  input  logic [XLEN-1:0] iTargetPC,
  output logic [XLEN-1:0] oPC
);
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;

  // Redirect beats stall so a squashed stall cannot freeze a wrong-path PC.
  always_comb begin
    w_next_pc = r_pc + XLEN'(PC_STEP);
    if (iBranchTaken)  w_next_pc = {iTargetPC[XLEN-1:2], 2'b00};
    else if (iStall)   w_next_pc = r_pc;
  end

  // PC register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_pc <= RESET_PC;
    else      r_pc <= w_next_pc;
  end

  assign oPC = r_pc;
endmodule

// File: rtl/pipelined_control_unit.sv
// Fetch/decode front end: PC, IF/ID, decode, registered ID/EX control word.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              IMEM_ADDR_WIDTH = 12
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iStall,
  input  logic                       iBranchTaken,
  input  logic [XLEN-1:0]            iTargetPC,
  input  logic                       iImemWe,
  input  logic [IMEM_ADDR_WIDTH-1:0] iImemWAddr,
  input  logic [31:0]                iImemWData,
  output logic                       oValid,
  output logic [XLEN-1:0]            oPC,
  output logic [XLEN-1:0]            oImmExt,
  output logic                       oRegWrite,
  output logic                       oMemWrite,
  output logic                       oAluSrc,
  output logic [3:0]                 oAluControl,
  output logic [2:0]                 oResultSrc,
  output logic [4:0]                 oRs1,
  output logic [4:0]                 oRs2,
  output logic [4:0]                 oRd,
  output InstructionTypes            oInstructionType,
  output InstructionSubTypes         oInstructionSubType
);
  logic [XLEN-1:0]    w_pc;
  logic [31:0]        w_instr;
  if_id_t             r_if_id;
  id_ex_ctrl_t        r_id_ex, w_id_ex_d;
  logic               w_reg_write, w_mem_write, w_alu_src, w_pcsrc_unused;
  logic [3:0]         w_alu_control;
  logic [2:0]         w_result_src;
  logic [31:0]        w_imm;
  logic [4:0]         w_rs1, w_rs2, w_rd;
  InstructionTypes    w_type;
  InstructionSubTypes w_sub;

  pc_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .iClk(iClk), .iRst(iRst), .iStall(iStall), .iBranchTaken(iBranchTaken),
    .iTargetPC(iTargetPC), .oPC(w_pc)
  );

  instr_mem #(.ADDR_W(IMEM_ADDR_WIDTH)) u_imem (
    .iClk(iClk), .iWe(iImemWe), .iWAddr(iImemWAddr), .iWData(iImemWData),
    .iAddr(w_pc[IMEM_ADDR_WIDTH+1:2]), .oRdata(w_instr)
  );

  // Branches resolve in execute, so the decoder's own PC-select is not used here.
  control_decoder u_dec (
    .iInstr(r_if_id.instr), .iZero(1'b0),
    .oRegWrite(w_reg_write), .oMemWrite(w_mem_write), .oAluSrc(w_alu_src),
    .oPCSrc(w_pcsrc_unused), .oAluControl(w_alu_control), .oResultSrc(w_result_src),
    .oImmExt(w_imm), .oRs1(w_rs1), .oRs2(w_rs2), .oRd(w_rd),
    .oType(w_type), .oSubType(w_sub)
  );

  // IF/ID: flush drops the slot, stall freezes it, otherwise capture the fetch.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)               r_if_id <= '0;
    else if (iBranchTaken)  r_if_id.valid <= 1'b0;
    else if (!iStall)       r_if_id <= '{instr: w_instr, pc: w_pc, valid: 1'b1};
  end

  // Next ID/EX word; bubbles and empty slots are all-zero so controls are valid-gated.
  always_comb begin
    w_id_ex_d = '0;
    if (!iBranchTaken && !iStall && r_if_id.valid) begin
      w_id_ex_d.valid       = 1'b1;
      w_id_ex_d.pc          = r_if_id.pc;
      w_id_ex_d.imm_ext     = w_imm;
      w_id_ex_d.reg_write   = w_reg_write;
      w_id_ex_d.mem_write   = w_mem_write;
      w_id_ex_d.alu_src     = w_alu_src;
      w_id_ex_d.alu_control = w_alu_control;
      w_id_ex_d.result_src  = w_result_src;
      w_id_ex_d.rs1         = w_rs1;
      w_id_ex_d.rs2         = w_rs2;
      w_id_ex_d.rd          = w_rd;
      w_id_ex_d.itype       = w_type;
      w_id_ex_d.isub        = w_sub;
    end
  end

  // ID/EX register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_id_ex <= '0;
    else      r_id_ex <= w_id_ex_d;
  end

  assign oValid              = r_id_ex.valid;
  assign oPC                 = r_id_ex.pc;
  assign oImmExt             = r_id_ex.imm_ext;
  assign oRegWrite           = r_id_ex.reg_write;
  assign oMemWrite           = r_id_ex.mem_write;
  assign oAluSrc             = r_id_ex.alu_src;
  assign oAluControl         = r_id_ex.alu_control;
  assign oResultSrc          = r_id_ex.result_src;
  assign oRs1                = r_id_ex.rs1;
  assign oRs2                = r_id_ex.rs2;
  assign oRd                 = r_id_ex.rd;
  assign oInstructionType    = r_id_ex.itype;
  assign oInstructionSubType = r_id_ex.isub;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench: directed pipeline scenarios plus randomized stall/branch traffic vs. a reference model.
module tb_pipelined_control_unit;
  import pipelined_control_unit_pkg::*;
  localparam int NW = 256;

  logic iClk = 1'b0;
  logic iRst, iStall, iBranchTaken, iImemWe;
  logic [31:0] iTargetPC, iImemWData;
  logic [11:0] iImemWAddr;
  logic oValid, oRegWrite, oMemWrite, oAluSrc;
  logic [31:0] oPC, oImmExt;
  logic [3:0] oAluControl;
  logic [2:0] oResultSrc;
  logic [4:0] oRs1, oRs2, oRd;
  InstructionTypes oInstructionType;
  InstructionSubTypes oInstructionSubType;

  logic w2Rst, w2We;
  logic [11:0] w2WAddr;
  logic [31:0] w2WData;
  logic o2Valid, o2RegWrite, o2MemWrite, o2AluSrc;
  logic [31:0] o2PC, o2ImmExt;
  logic [3:0] o2AluControl;
  logic [2:0] o2ResultSrc;
  logic [4:0] o2Rs1, o2Rs2, o2Rd;
  InstructionTypes o2Type;
  InstructionSubTypes o2Sub;

  int errors, checks;

  logic [96:0] all_out;
  assign all_out = {oValid, oPC, oImmExt, oRegWrite, oMemWrite, oAluSrc, oAluControl,
                    oResultSrc, oRs1, oRs2, oRd, oInstructionType, oInstructionSubType};

  pipelined_control_unit dut (
    .iClk(iClk), .iRst(iRst), .iStall(iStall), .iBranchTaken(iBranchTaken), .iTargetPC(iTargetPC),
    .iImemWe(iImemWe), .iImemWAddr(iImemWAddr), .iImemWData(iImemWData),
    .oValid(oValid), .oPC(oPC), .oImmExt(oImmExt), .oRegWrite(oRegWrite), .oMemWrite(oMemWrite),
    .oAluSrc(oAluSrc), .oAluControl(oAluControl), .oResultSrc(oResultSrc), .oRs1(oRs1),
    .oRs2(oRs2), .oRd(oRd), .oInstructionType(oInstructionType),
    .oInstructionSubType(oInstructionSubType)
  );

  pipelined_control_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .iClk(iClk), .iRst(w2Rst), .iStall(1'b0), .iBranchTaken(1'b0), .iTargetPC(32'h0),
    .iImemWe(w2We), .iImemWAddr(w2WAddr), .iImemWData(w2WData),
    .oValid(o2Valid), .oPC(o2PC), .oImmExt(o2ImmExt), .oRegWrite(o2RegWrite), .oMemWrite(o2MemWrite),
    .oAluSrc(o2AluSrc), .oAluControl(o2AluControl), .oResultSrc(o2ResultSrc), .oRs1(o2Rs1),
    .oRs2(o2Rs2), .oRd(o2Rd), .oInstructionType(o2Type), .oInstructionSubType(o2Sub)
  );

  always #5 iClk = ~iClk;

  // Program image and the decode each word must produce, derived while encoding.
  logic [31:0] prog [NW];
  logic [31:0] e_imm [NW];
  logic        e_rw [NW], e_mw [NW], e_as [NW];
  logic [3:0]  e_alu [NW], e_sub [NW];
  logic [2:0]  e_res [NW], e_ty [NW];

  // Model: next fetch address, decode slot, output slot.
  logic [31:0] m_pc, m_dpc, m_epc;
  logic        m_dv, m_ev;

  task automatic exp_set(input int w, input logic rw, input logic mw, input logic as_,
                         input logic [3:0] alu, input logic [2:0] res, input logic [31:0] imm,
                         input logic [2:0] ty, input logic [3:0] sub);
    e_rw[w] = rw; e_mw[w] = mw; e_as[w] = as_; e_alu[w] = alu; e_res[w] = res;
    e_imm[w] = imm; e_ty[w] = ty; e_sub[w] = sub;
  endtask

  // kind: 0 addi, 1 add, 2 sub, 3 sw, 4 lw, 5 lui, 6 xori; imm is the architectural value.
  task automatic set_instr(input int w, input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    case (kind)
      0: begin prog[w] = {imm[11:0], rs1, 3'b000, rd, 7'h13};
               exp_set(w, 1, 0, 1, ALU_ADD, RES_ALU, imm, IT_I, IST_ALU_IMM); end
      1: begin prog[w] = {7'b0000000, rs2, rs1, 3'b000, rd, 7'h33};
               exp_set(w, 1, 0, 0, ALU_ADD, RES_ALU, 0, IT_R, IST_ALU); end
      2: begin prog[w] = {7'b0100000, rs2, rs1, 3'b000, rd, 7'h33};
               exp_set(w, 1, 0, 0, ALU_SUB, RES_ALU, 0, IT_R, IST_ALU); end
      3: begin prog[w] = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
               exp_set(w, 0, 1, 1, ALU_ADD, RES_ALU, imm, IT_S, IST_STORE); end
      4: begin prog[w] = {imm[11:0], rs1, 3'b010, rd, 7'h03};
               exp_set(w, 1, 0, 1, ALU_ADD, RES_MEM, imm, IT_I, IST_LOAD); end
      5: begin prog[w] = {imm[31:12], rd, 7'h37};
               exp_set(w, 1, 0, 0, ALU_ADD, RES_IMM, imm, IT_U, IST_LUI); end
      default: begin prog[w] = {imm[11:0], rs1, 3'b100, rd, 7'h13};
               exp_set(w, 1, 0, 1, ALU_XOR, RES_ALU, imm, IT_I, IST_ALU_IMM); end
    endcase
  endtask

  task automatic build_program();
    logic [11:0] r12;
    logic [31:0] imm;
    int kind;
    set_instr(0, 0, 5'd1, 5'd0, 5'd0, 32'd5);   // addi x1,x0,5
    set_instr(1, 0, 5'd2, 5'd1, 5'd0, 32'd3);   // addi x2,x1,3
    set_instr(2, 3, 5'd0, 5'd0, 5'd2, 32'd0);   // sw x2,0(x0)
    for (int w = 3; w < NW; w++) begin
      kind = int'($urandom_range(0, 6));
      r12 = 12'($urandom);
      imm = (kind == 5) ? {20'($urandom), 12'h000} : {{20{r12[11]}}, r12};
      set_instr(w, kind, 5'($urandom), 5'($urandom), 5'($urandom), imm);
    end
  endtask

  task automatic load_program();
    for (int i = 0; i < NW; i++) begin
      iImemWe = 1'b1; iImemWAddr = 12'(i); iImemWData = prog[i];
      w2We = (i < 2); w2WAddr = (i == 0) ? 12'hFFF : 12'h000;
      w2WData = (i == 0) ? {12'd7, 5'd0, 3'b000, 5'd3, 7'h13} : prog[0];
      @(posedge iClk); #1;
    end
    iImemWe = 1'b0; w2We = 1'b0;
    @(negedge iClk);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_dv = 1'b0; m_ev = 1'b0; m_dpc = '0; m_epc = '0;
  endtask

  // One clock with the given inputs; returns at the following falling edge.
  task automatic tick(input logic st, input logic br, input logic [31:0] tgt);
    iStall = st; iBranchTaken = br; iTargetPC = tgt;
    @(posedge iClk);
    if (br) begin m_ev = 1'b0; m_dv = 1'b0; m_pc = {tgt[31:2], 2'b00}; end
    else if (st) m_ev = 1'b0;
    else begin m_ev = m_dv; m_epc = m_dpc; m_dv = 1'b1; m_dpc = m_pc; m_pc = m_pc + 32'd4; end
    @(negedge iClk);
    iStall = 1'b0; iBranchTaken = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iClk); iRst = 1'b1;
    @(posedge iClk); @(negedge iClk); iRst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    iRst = 1'b0; model_reset();
    tick(0, 0, 0);
    checks++;
    if (oValid !== 1'b0) begin errors++; $display("FAIL first_edge_valid: got %b expected 0", oValid); end
    tick(0, 0, 0);
    checks++;
    if ({oValid, oPC} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL second_edge_output: got valid=%b pc=%h expected valid=1 pc=0", oValid, oPC);
    end
    repeat (3) tick(0, 0, 0);
    #2; iRst = 1'b1; #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", all_out); end
    @(negedge iClk); iRst = 1'b0; model_reset();
    tick(0, 0, 0); tick(0, 0, 0);
    checks++;
    if ({oValid, oPC, oRd} !== {1'b1, 32'h0, 5'd1}) begin
      errors++; $display("FAIL reset_restart: got valid=%b pc=%h rd=%0d expected 1/0/1", oValid, oPC, oRd);
    end
  endtask

  task automatic test_straight();
    do_reset();
    tick(0, 0, 0); tick(0, 0, 0);
    checks++;
    if ({oValid, oPC, oRegWrite, oMemWrite, oRd, oImmExt} !== {1'b1, 32'h0, 1'b1, 1'b0, 5'd1, 32'd5}) begin
      errors++; $display("FAIL straight_addi1: got pc=%h rw=%b rd=%0d imm=%h", oPC, oRegWrite, oRd, oImmExt);
    end
    tick(0, 0, 0);
    checks++;
    if ({oValid, oPC, oRs1, oRd, oImmExt} !== {1'b1, 32'h4, 5'd1, 5'd2, 32'd3}) begin
      errors++; $display("FAIL straight_addi2: got pc=%h rs1=%0d rd=%0d imm=%h", oPC, oRs1, oRd, oImmExt);
    end
    tick(0, 0, 0);
    checks++;
    if ({oValid, oPC, oMemWrite, oRegWrite, oImmExt, oRs2} !== {1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 5'd2}) begin
      errors++; $display("FAIL straight_sw: got pc=%h mw=%b rw=%b imm=%h rs2=%0d expected 8/1/0/0/2",
                         oPC, oMemWrite, oRegWrite, oImmExt, oRs2);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
    do_reset();
    tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0);
      checks++;
      if ({oValid, oRegWrite, oMemWrite} !== 3'b000) begin
        errors++; $display("FAIL stall_bubble%0d: got valid=%b rw=%b mw=%b expected 0", i, oValid, oRegWrite, oMemWrite);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      checks++;
      if ({oValid, oPC} !== {1'b1, exp_pc[i]}) begin
        errors++; $display("FAIL stall_resume%0d: got valid=%b pc=%h expected pc=%h", i, oValid, oPC, exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (6) tick(0, 0, 0);
    checks++;
    if ({oValid, oPC} !== {1'b1, 32'h10}) begin
      errors++; $display("FAIL branch_pre: got pc=%h expected 10", oPC);
    end
    tick(0, 1, 32'h40);
    checks++;
    if (oValid !== 1'b0) begin errors++; $display("FAIL branch_bubble1: got valid=%b", oValid); end
    tick(0, 0, 0);
    checks++;
    if (oValid !== 1'b0) begin errors++; $display("FAIL branch_bubble2: got valid=%b", oValid); end
    tick(0, 0, 0);
    checks++;
    if ({oValid, oPC} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL branch_target: got valid=%b pc=%h expected 1/40", oValid, oPC);
    end
  endtask

  task automatic test_stall_branch();
    tick(1, 1, 32'h23);
    checks++;
    if ({oValid, oRegWrite} !== 2'b00) begin errors++; $display("FAIL stbr_bubble1: got valid=%b", oValid); end
    tick(0, 0, 0);
    checks++;
    if (oValid !== 1'b0) begin errors++; $display("FAIL stbr_bubble2: got valid=%b", oValid); end
    tick(0, 0, 0);
    checks++;
    if ({oValid, oPC} !== {1'b1, 32'h20}) begin
      errors++; $display("FAIL stbr_target: got valid=%b pc=%h expected 1/20", oValid, oPC);
    end
    tick(0, 0, 0);
    checks++;
    if ({oValid, oPC} !== {1'b1, 32'h24}) begin
      errors++; $display("FAIL stbr_next: got valid=%b pc=%h expected 1/24", oValid, oPC);
    end
  endtask

  task automatic test_wrap();
    @(negedge iClk); w2Rst = 1'b0;
    @(posedge iClk); @(negedge iClk);
    checks++;
    if (o2Valid !== 1'b0) begin errors++; $display("FAIL wrap_first_edge: got valid=%b", o2Valid); end
    @(posedge iClk); @(negedge iClk);
    checks++;
    if ({o2Valid, o2PC, o2ImmExt, o2Rd} !== {1'b1, 32'hFFFF_FFFC, 32'd7, 5'd3}) begin
      errors++; $display("FAIL wrap_top: got valid=%b pc=%h imm=%h expected 1/fffffffc/7", o2Valid, o2PC, o2ImmExt);
    end
    @(posedge iClk); @(negedge iClk);
    checks++;
    if ({o2Valid, o2PC} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap_zero: got valid=%b pc=%h expected 1/0", o2Valid, o2PC);
    end
  endtask

  task automatic test_random();
    logic st, br;
    logic [31:0] iw;
    logic [63:0] exp_f, act_f;
    int w;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      st = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 7) == 0) || (m_pc > 32'h380);
      tick(st, br, 32'($urandom_range(0, 32'h3FF)));
      checks++;
      if (oValid !== m_ev) begin
        errors++; $display("FAIL rand_valid c%0d: got %b expected %b", c, oValid, m_ev);
      end else if (m_ev) begin
        w = int'(m_epc[9:2]);
        iw = prog[w];
        exp_f = {e_rw[w], e_mw[w], e_as[w], e_alu[w], e_res[w], e_imm[w],
                 iw[19:15], iw[24:20], iw[11:7], e_ty[w], e_sub[w]};
        act_f = {oRegWrite, oMemWrite, oAluSrc, oAluControl, oResultSrc, oImmExt,
                 oRs1, oRs2, oRd, oInstructionType, oInstructionSubType};
        checks++;
        if (act_f !== exp_f || oPC !== m_epc) begin
          errors++; $display("FAIL rand_fields c%0d: got pc=%h f=%h expected pc=%h f=%h", c, oPC, act_f, m_epc, exp_f);
        end
      end else begin
        checks++;
        if ({oRegWrite, oMemWrite, oAluSrc} !== 3'b000) begin
          errors++; $display("FAIL rand_bubble c%0d: got rw/mw/as=%b expected 000", c, {oRegWrite, oMemWrite, oAluSrc});
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0; checks = 0;
    iRst = 1'b1; w2Rst = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iTargetPC = '0;
    iImemWe = 1'b0; iImemWAddr = '0; iImemWData = '0; w2We = 1'b0; w2WAddr = '0; w2WData = '0;
    model_reset();
    build_program();
    load_program();
    test_reset();
    test_straight();
    test_stall();
    test_branch();
    test_stall_branch();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
